// File: rtl/ctr191_pkg.sv
// Shared definitions for the am25ls191 counter sequencer: mode codes and FSM states.
package ctr191_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_SWEEP    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // The unused fourth mode code behaves as a one-shot.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_ONESHOT : m;
  endfunction

endpackage

// File: rtl/ctr191_sequencer.sv
// Drives load_/ent_/ud of an external am25ls191 up/down counter to provide
// one-shot, periodic and triangle-sweep timing from its max/min flag.
module ctr191_sequencer
  import ctr191_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] period,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] ctr_q,
  input  logic             ctr_mxmn,
  output logic [WIDTH-1:0] ctr_in,
  output logic             ctr_load_,
  output logic             ctr_ent_,
  output logic             ctr_ud,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             dir
);

  state_t     state, state_n;
  logic [1:0] mode_r, mode_n;
  logic       dir_n;
  logic       tick_n;
  logic       done_n;

  assign ctr_in = period;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_r <= '0;
      dir    <= 1'b0;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      mode_r <= mode_n;
      dir    <= dir_n;
      tick   <= tick_n;
      done   <= done_n;
      // The max/min flag must agree with q for the direction being driven.
      if (state == ST_RUN)
        assert (ctr_mxmn == (ctr_ud ? (ctr_q == '0) : (ctr_q == '1)));
    end
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode_r;
    dir_n     = dir;
    tick_n    = 1'b0;
    done_n    = 1'b0;
    ctr_ent_  = 1'b1;
    ctr_load_ = 1'b1;
    ctr_ud    = (mode_r == MODE_SWEEP) ? dir : 1'b1;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LOAD;
          mode_n  = norm_mode(mode);
          if (norm_mode(mode) == MODE_SWEEP)
            dir_n = 1'b0;
        end
      end

      ST_LOAD: begin
        ctr_ent_  = 1'b0;
        ctr_load_ = 1'b0;
        state_n   = stop ? ST_IDLE : ST_RUN;
      end

      ST_RUN: begin
        // Pins ignore stop, so a count or reload step can still land on the abort edge.
        if (!ctr_mxmn) begin
          ctr_ent_ = 1'b0;
        end else if (mode_r == MODE_PERIODIC) begin
          ctr_ent_  = 1'b0;
          ctr_load_ = 1'b0;
        end

        if (stop) begin
          state_n = ST_IDLE;
        end else if (ctr_mxmn) begin
          tick_n = 1'b1;
          case (mode_r)
            MODE_PERIODIC: ;
            MODE_SWEEP:    dir_n = ~dir;
            default: begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          endcase
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (rst) begin
      ctr_ent_  = 1'b1;
      ctr_load_ = 1'b1;
    end
  end

endmodule

// File: tb/tb_ctr191_sequencer.sv
// Directed bench for ctr191_sequencer with a behavioural am25ls191 load; per-cycle
// expectations are queued as stimulus is applied and compared on the falling edge.
module tb_ctr191_sequencer;
  import ctr191_pkg::*;

  localparam int unsigned W = 4;
  localparam int X = -1;

  logic         clk = 1'b0;
  logic         rst, start, stop;
  logic [1:0]   mode;
  logic [W-1:0] period;
  logic [W-1:0] ctr_q, ctr_in;
  logic         ctr_mxmn, ctr_load_, ctr_ent_, ctr_ud;
  logic         busy, tick, done, dir;

  ctr191_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .period(period), .mode(mode), .start(start), .stop(stop),
    .ctr_q(ctr_q), .ctr_mxmn(ctr_mxmn), .ctr_in(ctr_in), .ctr_load_(ctr_load_),
    .ctr_ent_(ctr_ent_), .ctr_ud(ctr_ud), .busy(busy), .tick(tick), .done(done), .dir(dir)
  );

  always #5 clk = ~clk;

  // am25ls191 behaviour on the shared clock: no reset, counts only when enabled.
  always @(posedge clk)
    if (ctr_ent_ == 1'b0)
      ctr_q <= (ctr_load_ == 1'b0) ? ctr_in : (ctr_ud ? ctr_q - 1'b1 : ctr_q + 1'b1);

  assign ctr_mxmn = ctr_ud ? (ctr_q == '0) : (ctr_q == '1);

  typedef struct {
    string tag;
    int q, busy, tick, done, ent, load, ud, dir;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    if (exp >= 0) begin
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".q"},     int'(ctr_q),     e.q);
      chk({e.tag, ".busy"},  int'(busy),      e.busy);
      chk({e.tag, ".tick"},  int'(tick),      e.tick);
      chk({e.tag, ".done"},  int'(done),      e.done);
      chk({e.tag, ".ent_"},  int'(ctr_ent_),  e.ent);
      chk({e.tag, ".load_"}, int'(ctr_load_), e.load);
      chk({e.tag, ".ud"},    int'(ctr_ud),    e.ud);
      chk({e.tag, ".dir"},   int'(dir),       e.dir);
    end
  end

  // Queue what the current cycle must show, then advance to the next cycle.
  task automatic step(input string tag, input int q, input int b, input int t, input int d,
                      input int ent, input int ld, input int ud, input int dr);
    exp_t e;
    e.tag = tag; e.q = q; e.busy = b; e.tick = t; e.done = d;
    e.ent = ent; e.load = ld; e.ud = ud; e.dir = dr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; period = '0;
    @(posedge clk);
    #1;

    // Reset and quiet idle
    step("rst0", X, 0, 0, 0, 1, 1, X, 0);
    step("rst1", X, 0, 0, 0, 1, 1, X, 0);
    rst = 1'b0;
    step("idle0", X, 0, 0, 0, 1, 1, 1, 0);
    step("idle1", X, 0, 0, 0, 1, 1, 1, 0);

    // One-shot, period 3
    mode = 2'd0; period = 4'd3; start = 1'b1;
    step("os_start", X, 0, 0, 0, 1, 1, 1, X);
    start = 1'b0;
    step("os_load", X, 1, 0, 0, 0, 0, X, X);
    step("os_q3", 3, 1, 0, 0, 0, 1, 1, X);
    step("os_q2", 2, 1, 0, 0, 0, 1, 1, X);
    step("os_q1", 1, 1, 0, 0, 0, 1, 1, X);
    step("os_q0", 0, 1, 0, 0, 1, 1, 1, X);
    step("os_done", 0, 0, 1, 1, 1, 1, 1, X);
    step("os_after", 0, 0, 0, 0, 1, 1, 1, X);

    // Periodic, period 2, period raised to 4 mid-run, mode change ignored, then stop
    mode = 2'd1; period = 4'd2; start = 1'b1;
    step("pd_start", 0, 0, 0, 0, 1, 1, 1, X);
    start = 1'b0;
    step("pd_load", X, 1, 0, 0, 0, 0, X, X);
    mode = 2'd0;
    step("pd_q2a", 2, 1, 0, 0, 0, 1, 1, X);
    step("pd_q1a", 1, 1, 0, 0, 0, 1, 1, X);
    step("pd_q0a", 0, 1, 0, 0, 0, 0, 1, X);
    step("pd_q2b", 2, 1, 1, 0, 0, 1, 1, X);
    period = 4'd4;
    step("pd_q1b", 1, 1, 0, 0, 0, 1, 1, X);
    step("pd_q0b", 0, 1, 0, 0, 0, 0, 1, X);
    step("pd_q4", 4, 1, 1, 0, 0, 1, 1, X);
    stop = 1'b1;
    step("pd_q3_stop", 3, 1, 0, 0, 0, 1, 1, X);
    stop = 1'b0;
    step("pd_idle", 2, 0, 0, 0, 1, 1, 1, X);
    step("pd_hold", 2, 0, 0, 0, 1, 1, 1, X);

    // Periodic, period 0: tick stays high after the first terminal
    mode = 2'd1; period = 4'd0; start = 1'b1;
    step("p0_start", 2, 0, 0, 0, 1, 1, 1, X);
    start = 1'b0;
    step("p0_load", X, 1, 0, 0, 0, 0, X, X);
    step("p0_r1", 0, 1, 0, 0, 0, 0, 1, X);
    step("p0_r2", 0, 1, 1, 0, 0, 0, 1, X);
    step("p0_r3", 0, 1, 1, 0, 0, 0, 1, X);
    step("p0_r4", 0, 1, 1, 0, 0, 0, 1, X);
    stop = 1'b1;
    step("p0_stop", 0, 1, 1, 0, 0, 0, 1, X);
    stop = 1'b0;
    step("p0_idle", 0, 0, 0, 0, 1, 1, 1, X);

    // Triangle sweep from 14
    mode = 2'd2; period = 4'd14; start = 1'b1;
    step("sw_start", 0, 0, 0, 0, 1, 1, 1, X);
    start = 1'b0;
    step("sw_load", X, 1, 0, 0, 0, 0, 0, 0);
    step("sw_q14", 14, 1, 0, 0, 0, 1, 0, 0);
    step("sw_top0", 15, 1, 0, 0, 1, 1, 0, 0);
    step("sw_top1", 15, 1, 1, 0, 0, 1, 1, 1);
    for (int v = 14; v >= 1; v--)
      step($sformatf("sw_dn%0d", v), v, 1, 0, 0, 0, 1, 1, 1);
    step("sw_bot0", 0, 1, 0, 0, 1, 1, 1, 1);
    step("sw_bot1", 0, 1, 1, 0, 0, 1, 0, 0);
    step("sw_up1", 1, 1, 0, 0, 0, 1, 0, 0);
    stop = 1'b1;
    step("sw_stop", 2, 1, 0, 0, 0, 1, 0, 0);
    stop = 1'b0;
    step("sw_idle", 3, 0, 0, 0, 1, 1, 0, 0);
    step("sw_hold", 3, 0, 0, 0, 1, 1, 0, 0);

    // One-shot from 9: start during RUN ignored, stop at q=5
    mode = 2'd0; period = 4'd9; start = 1'b1;
    step("ab_start", 3, 0, 0, 0, 1, 1, 0, 0);
    start = 1'b0;
    step("ab_load", X, 1, 0, 0, 0, 0, X, X);
    for (int v = 9; v >= 5; v--) begin
      if (v == 7) begin start = 1'b1; mode = 2'd2; end
      if (v == 5) stop = 1'b1;
      step($sformatf("ab_q%0d", v), v, 1, 0, 0, 0, 1, 1, X);
      start = 1'b0; mode = 2'd0; stop = 1'b0;
    end
    step("ab_idle", 4, 0, 0, 0, 1, 1, 1, X);
    step("ab_hold", 4, 0, 0, 0, 1, 1, 1, X);

    // Mode 3 acts as one-shot; start beats stop in IDLE
    mode = 2'd3; period = 4'd1; start = 1'b1; stop = 1'b1;
    step("m3_start", 4, 0, 0, 0, 1, 1, 1, X);
    start = 1'b0; stop = 1'b0;
    step("m3_load", X, 1, 0, 0, 0, 0, X, X);
    step("m3_q1", 1, 1, 0, 0, 0, 1, 1, X);
    step("m3_q0", 0, 1, 0, 0, 1, 1, 1, X);
    step("m3_done", 0, 0, 1, 1, 1, 1, 1, X);

    // Reset on the terminal cycle clears the pending tick/done
    mode = 2'd0; period = 4'd0; start = 1'b1;
    step("mr_start", 0, 0, 0, 0, 1, 1, 1, X);
    start = 1'b0;
    step("mr_load", X, 1, 0, 0, 0, 0, X, X);
    rst = 1'b1;
    step("mr_term_rst", 0, 1, 0, 0, 1, 1, 1, X);
    rst = 1'b0;
    step("mr_idle", 0, 0, 0, 0, 1, 1, 1, 0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctr191_sequencer.md
Name: ctr191_sequencer

Overview:
- Controller that drives the control pins of an external am25ls191-pinout up/down counter: in, load_, ent_, ud.
- Reads back the counter's q and mxmn to detect terminal count.
- Provides one-shot timer, periodic rate generator, and triangle-sweep modes to the surrounding microcode/sequencer logic.
- Sits beside the counter on the same clock. It replaces ad-hoc glue that reloads and reverses the counter.

Parameters:
- WIDTH, 4, width of the counter datapath. Must match the attached counter.

Ports:
- clk  input  1  system clock, rising edge; the same clock feeds the counter.
- rst  input  1  synchronous active-high reset.
- period  input  WIDTH  load value. Sampled in LOAD, and in RUN at each periodic reload.
- mode  input  2  0=one-shot down, 1=periodic down, 2=triangle sweep, 3=treated as 0. Sampled on start.
- start  input  1  start request, sampled in IDLE only.
- stop  input  1  abort request, sampled in LOAD/RUN.
- ctr_q  input  WIDTH  counter q.
- ctr_mxmn  input  1  counter max/min: all-ones when ud=0, all-zeros when ud=1.
- ctr_in  output  WIDTH  counter parallel data; always equals period.
- ctr_load_  output  1  counter load, active low.
- ctr_ent_  output  1  counter enable, active low.
- ctr_ud  output  1  0=count up, 1=count down.
- busy  output  1  high in LOAD/RUN.
- tick  output  1  registered one-cycle pulse per terminal event.
- done  output  1  registered one-cycle pulse at one-shot completion.
- dir  output  1  current sweep direction register (0=up).

Behaviour:
- Counter contract:
  - The counter updates on posedge clk only when ent_=0.
  - load_=0 loads ctr_in; otherwise it counts per ud.
  - The counter has no reset; its value after reset is undefined until LOAD.
- Pin outputs are combinational from state, mode_r, dir and ctr_mxmn.
- While rst=1: ctr_ent_=1 and ctr_load_=1 regardless of state.
- States: IDLE, LOAD, RUN.
- Reset values: state=IDLE, mode_r=0, dir=0, tick=0, done=0, busy=0.
- IDLE:
  - ctr_ent_=1, ctr_load_=1, ctr_ud=1 (or dir in mode 2).
  - start=1 latches mode_r; next state LOAD. In mode 2, dir is cleared to 0.
- LOAD:
  - ctr_ent_=0, ctr_load_=0. The counter holds period after the edge.
  - Next state RUN. stop=1 goes to IDLE instead; the load still occurs.
- RUN:
  - ctr_load_=1, ctr_ud=1 in modes 0/1, ctr_ud=dir in mode 2.
  - ctr_ent_=0 while ctr_mxmn=0.
- Terminal (RUN and ctr_mxmn=1):
  - Mode 0: ctr_ent_=1 (hold at 0). Next state IDLE; tick=1 and done=1 for the next cycle.
  - Mode 1: ctr_ent_=0, ctr_load_=0 (reload period in the same cycle). Stay in RUN; tick=1 next cycle.
  - Mode 2: ctr_ent_=1 (dwell one cycle). dir toggles; tick=1 next cycle. Runs until stop.
- Timing:
  - One-shot total: LOAD plus period+1 RUN cycles; done follows.
  - Periodic: tick spacing is period+1 cycles. With period=0, tick stays high continuously.
  - Sweep: full triangle over 0..2^WIDTH-1 is 2^(WIDTH+1) cycles. Each end value appears for two consecutive cycles.
- stop:
  - Priority over terminal handling; next state IDLE; no tick and no done.
  - ctr_ent_ is unaffected in the stop cycle, so a count step may still occur at that edge.
- start while busy is ignored. start and stop together in IDLE: start wins.
- Mid-operation reset: IDLE on the next edge. Pending tick/done cleared. Counter value left as-is.
- mode and period changes during RUN: mode ignored; period is used at the next reload.

Decomposition:
- Shared package ctr191_pkg:
  - Mode constants MODE_ONESHOT=0, MODE_PERIODIC=1, MODE_SWEEP=2.
  - State encoding IDLE/LOAD/RUN.
- No sub-module in RTL.
- The bench instantiates the codebase's am25ls191 counter (WIDTH=4) as the load, driven from the same clk.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> busy=0, tick=0, done=0, ctr_ent_=1, ctr_load_=1 in all cycles of and after reset until start.
- One-shot: mode=0, period=3, start pulse.
  - Expect LOAD at cycle L.
  - q=3,2,1,0 in cycles L+1..L+4.
  - done=tick=1 only in L+5.
  - busy=0 from L+5; q remains 0.
- Periodic: mode=1, period=2 -> q cycles 2,1,0,2,1,0; tick high every 3rd cycle. With period=0 -> tick continuously 1 after the first terminal.
- Sweep: mode=2, period=14 -> q=14,15,15,14,...,1,0,0,1.
  - tick pulses after each doubled end value.
  - dir/ctr_ud flip 0->1 at 15 and 1->0 at 0.
- Abort/ignore: mode=0, period=9, stop asserted while q=5 -> q=4 after the edge, state IDLE, no done. start pulsed during RUN has no effect on q sequence or mode.
